// File: rtl/keypad_encoder.sv
// keypad_encoder: scans a 4x4 active-low keypad, debounces, and hands one key code per press over valid/ready.
// Optional held-key auto-repeat is compiled in with KEYPAD_REPEAT_EN.
module keypad_encoder #(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int REPEAT_SCANS   = 8
) (
  input  logic       JM1222HM_clk,
  input  logic       JM1222HM_rst,
  output logic [3:0] JM1222HM_col,
  input  logic [3:0] JM1222HM_row,
  output logic [3:0] JM1222HM_code,
  output logic       JM1222HM_valid,
  input  logic       JM1222HM_ready,
  output logic       JM1222HM_ovf
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int RW = $clog2(REPEAT_SCANS + 1);
`ifdef KEYPAD_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;
  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    col_q, col_d, hits_q, hits_d, hits_new, row_idx;
  logic [3:0]    sync1_q, sync2_q, low, key_q, key_d, key_new;
  logic [3:0]    cnt_q, cnt_d, cand_q, cand_d, code_q, code_d;
  logic [2:0]    nlow, tot;
  logic [RW-1:0] rep_q, rep_d;
  logic          sample, scan_end, none, single, match, emit, xfer;
  logic          valid_q, valid_d, ovf_q, ovf_d;
  // Scan sequencing; hits saturates at 2 so MULTI needs no wider count.
  always_comb begin
    low      = ~sync2_q;
    nlow     = {2'b0, low[0]} + {2'b0, low[1]} + {2'b0, low[2]} + {2'b0, low[3]};
    row_idx  = low[3] ? 2'd3 : low[2] ? 2'd2 : low[1] ? 2'd1 : 2'd0;
    tot      = {1'b0, hits_q} + nlow;
    hits_new = (tot > 3'd1) ? 2'd2 : tot[1:0];
    key_new  = (nlow == 3'd1) ? {row_idx, col_q} : key_q;
    sample   = div_q == DW'(SCAN_DIV - 1);
    scan_end = sample && (col_q == 2'd3);
    div_d    = sample ? '0 : div_q + DW'(1);
    col_d    = sample ? col_q + 2'd1 : col_q;
    hits_d   = scan_end ? 2'd0 : sample ? hits_new : hits_q;
    key_d    = scan_end ? 4'd0 : sample ? key_new : key_q;
    none     = hits_new == 2'd0;
    single   = hits_new == 2'd1;
    match    = single && (key_new == cand_q);
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    rep_d   = rep_q;
    emit    = 1'b0;
    if (scan_end) begin
      case (state_q)
        IDLE: if (single) begin
          cand_d = key_new;
          if (DEBOUNCE_SCANS == 1) begin
            emit    = 1'b1;
            state_d = HELD;
            cnt_d   = 4'd0;
            rep_d   = '0;
          end else begin
            state_d = DEBOUNCE;
            cnt_d   = 4'd1;
          end
        end
        DEBOUNCE: if (match) begin
          if (cnt_q + 4'd1 == 4'(DEBOUNCE_SCANS)) begin
            emit    = 1'b1;
            state_d = HELD;
            cnt_d   = 4'd0;
            rep_d   = '0;
          end else cnt_d = cnt_q + 4'd1;
        end else if (single) begin
          cand_d = key_new;
          cnt_d  = 4'd1;
        end else begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
        HELD: begin
          cnt_d = none ? cnt_q + 4'd1 : 4'd0;
          if (none && (cnt_q + 4'd1 == 4'(DEBOUNCE_SCANS))) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end
          // Repeat counter runs in every build; only the emit is gated by the feature.
          if (match) begin
            rep_d = (rep_q + RW'(1) == RW'(REPEAT_SCANS)) ? '0 : rep_q + RW'(1);
            emit  = REPEAT_ON && (rep_q + RW'(1) == RW'(REPEAT_SCANS));
          end else if (!single) rep_d = '0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end
  always_comb begin
    xfer    = valid_q && JM1222HM_ready;
    code_d  = (emit && (!valid_q || xfer)) ? cand_d : code_q;
    valid_d = emit || (valid_q && !xfer);
    ovf_d   = ovf_q || (emit && valid_q && !xfer);
  end
  always_ff @(posedge JM1222HM_clk) begin
    if (JM1222HM_rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      col_q   <= 2'd0;
      hits_q  <= 2'd0;
      key_q   <= 4'd0;
      sync1_q <= 4'd0;
      sync2_q <= 4'd0;
      cnt_q   <= 4'd0;
      cand_q  <= 4'd0;
      rep_q   <= '0;
      code_q  <= 4'd0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      col_q   <= col_d;
      hits_q  <= hits_d;
      key_q   <= key_d;
      sync1_q <= JM1222HM_row;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      rep_q   <= rep_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end
  assign JM1222HM_col   = ~(4'b0001 << col_q);
  assign JM1222HM_code  = code_q;
  assign JM1222HM_valid = valid_q;
  assign JM1222HM_ovf   = ovf_q;
endmodule

// File: tb/tb_keypad_encoder.sv
// tb_keypad_encoder: directed keypad scenarios against hand-computed cycle timing (SCAN_DIV=4, DEBOUNCE_SCANS=3).
module tb_keypad_encoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready = 1'b0;
  logic [15:0] keys = 16'h0;
  logic [3:0]  col, row, code;
  logic        valid, ovf;
  int          checks = 0, errors = 0;
  int          cyc = 0, xfer_n = 0, last_cyc = 0, prev_cyc = 0, base = 0;
  logic [3:0]  last_code = 4'h0;
  always #5 clk = ~clk;
  keypad_encoder #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3), .REPEAT_SCANS(8)) dut (
    .JM1222HM_clk(clk), .JM1222HM_rst(rst), .JM1222HM_col(col), .JM1222HM_row(row),
    .JM1222HM_code(code), .JM1222HM_valid(valid), .JM1222HM_ready(ready), .JM1222HM_ovf(ovf)
  );
  // Passive matrix: a row reads low when a pressed key joins it to the driven column.
  always_comb for (int r = 0; r < 4; r++) row[r] = ~|(keys[4*r +: 4] & ~col);
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!rst && valid && ready) begin
    xfer_n    = xfer_n + 1;
    last_code = code;
    prev_cyc  = last_cyc;
    last_cyc  = cyc;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
  endtask
  initial begin
    do_reset();
    check("rst_col", 32'(col), 32'hE);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_code", 32'(code), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    wait_cycles(4); check("col1", 32'(col), 32'hD);
    wait_cycles(4); check("col2", 32'(col), 32'hB);
    wait_cycles(4); check("col3", 32'(col), 32'h7);
    wait_cycles(4); check("col_wrap", 32'(col), 32'hE);
    ready = 1'b1;
    do_reset();
    base = xfer_n;
    keys = 16'h1 << 9;
    wait_cycles(47); check("press9_pre", 32'(valid), 32'h0);
    wait_cycles(1);  check("press9_valid", 32'(valid), 32'h1);
    check("press9_code", 32'(code), 32'h9);
    wait_cycles(1);  check("press9_taken", 32'(valid), 32'h0);
    wait_cycles(271);
`ifdef KEYPAD_REPEAT_EN
    check("press9_count", 32'(xfer_n - base), 32'd3);
`else
    check("press9_count", 32'(xfer_n - base), 32'd1);
`endif
    keys = 16'h0;
    wait_cycles(64);
    do_reset();
    base = xfer_n;
    for (int i = 0; i < 10; i++) begin
      keys = (i % 2 == 0) ? 16'h1 << 5 : 16'h0;
      wait_cycles(16);
    end
    keys = 16'h0;
    wait_cycles(64);
    check("bounce_count", 32'(xfer_n - base), 32'd0);
    check("bounce_valid", 32'(valid), 32'h0);
    do_reset();
    base = xfer_n;
    keys = 16'h0081;
    wait_cycles(160);
    check("multi_count", 32'(xfer_n - base), 32'd0);
    keys = 16'h0001;
    wait_cycles(64);
    check("multi_rel_count", 32'(xfer_n - base), 32'd1);
    check("multi_rel_code", 32'(last_code), 32'h0);
    keys = 16'h0;
    wait_cycles(64);
    ready = 1'b0;
    do_reset();
    base = xfer_n;
    keys = 16'h1 << 5;
    wait_cycles(48);
    check("ovf_first_valid", 32'(valid), 32'h1);
    check("ovf_first_code", 32'(code), 32'h5);
    check("ovf_first_ovf", 32'(ovf), 32'h0);
    wait_cycles(16);
    keys = 16'h0;
    wait_cycles(64);
    keys = 16'h1 << 6;
    wait_cycles(64);
    check("ovf_set", 32'(ovf), 32'h1);
    check("ovf_code_kept", 32'(code), 32'h5);
    check("ovf_valid_kept", 32'(valid), 32'h1);
    keys = 16'h0;
    wait_cycles(64);
    ready = 1'b1;
    wait_cycles(1);
    check("ovf_drain_valid", 32'(valid), 32'h0);
    check("ovf_sticky", 32'(ovf), 32'h1);
    check("ovf_drain_count", 32'(xfer_n - base), 32'd1);
    check("ovf_drain_code", 32'(last_code), 32'h5);
    ready = 1'b0;
    do_reset();
    base = xfer_n;
    keys = 16'h1 << 5;
    wait_cycles(64);
    keys = 16'h0;
    wait_cycles(64);
    keys = 16'h1 << 6;
    wait_cycles(47);
    check("simul_pre_code", 32'(code), 32'h5);
    ready = 1'b1;
    wait_cycles(1);
    check("simul_valid", 32'(valid), 32'h1);
    check("simul_code", 32'(code), 32'h6);
    check("simul_no_ovf", 32'(ovf), 32'h0);
    wait_cycles(1);
    check("simul_drained", 32'(valid), 32'h0);
    check("simul_count", 32'(xfer_n - base), 32'd2);
    check("simul_last", 32'(last_code), 32'h6);
    keys = 16'h0;
    wait_cycles(64);
    do_reset();
    keys = 16'h1 << 10;
    wait_cycles(40);
    do_reset();
    base = xfer_n;
    wait_cycles(47);
    check("rstmid_pre", 32'(valid), 32'h0);
    check("rstmid_count", 32'(xfer_n - base), 32'd0);
    wait_cycles(1);
    check("rstmid_valid", 32'(valid), 32'h1);
    check("rstmid_code", 32'(code), 32'hA);
    keys = 16'h0;
    wait_cycles(80);
`ifdef KEYPAD_REPEAT_EN
    do_reset();
    base = xfer_n;
    keys = 16'h1 << 15;
    wait_cycles(700);
    check("rep_count", 32'(xfer_n - base), 32'd6);
    check("rep_code", 32'(last_code), 32'hF);
    check("rep_spacing", 32'(last_cyc - prev_cyc), 32'd128);
    keys = 16'h0;
    wait_cycles(80);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
